// File: rtl/data_recv_pkg.sv
// Shared constants and state encoding for the single-wire frame link.
// The same numbers must be used by the transmitter on the other end.
package data_recv_pkg;

    localparam int BIT_CLKS  = 50;
    localparam int HDR_BITS  = 40;
    localparam int IDLE_BITS = 8;
    localparam int DATA_BITS = 8;

    localparam logic [HDR_BITS-1:0] HDR_PAT = 40'hAA2A8AA020;

    localparam int PH_W   = $clog2(BIT_CLKS);
    localparam int BIDX_W = $clog2(HDR_BITS);
    localparam int DIDX_W = $clog2(DATA_BITS);
    localparam int ZC_W   = $clog2(IDLE_BITS + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BIT_CLKS - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(BIT_CLKS / 2);
    localparam logic [BIDX_W-1:0] HDR_LAST  = BIDX_W'(HDR_BITS - 1);
    localparam logic [DIDX_W-1:0] DIDX_LAST = DIDX_W'(DATA_BITS - 1);
    localparam logic [ZC_W-1:0]   ZC_MAX    = ZC_W'(IDLE_BITS);
    localparam logic [ZC_W-1:0]   ZC_ARM    = ZC_W'(IDLE_BITS - 1);

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        IDLE = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } state_t;

endpackage

// File: rtl/data_recv_if.sv
// Link-side bundle of the frame receiver: serial input plus byte/status outputs.
// master = whoever drives the line and consumes bytes, slave = the receiver.
interface data_recv_if;
    import data_recv_pkg::*;

    logic                 rxd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 hdr_err;
    logic                 busy;

    modport master (
        output rxd,
        input  data_out,
        input  data_valid,
        input  hdr_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output data_out,
        output data_valid,
        output hdr_err,
        output busy
    );

endinterface

// File: rtl/data_recv_sampler.sv
// Front end of the receiver: brings rxd into the clk domain, flags edges and
// produces one sample strobe per bit period. A realign request recentres the
// phase so the next strobe lands half a bit after the edge that caused it.
module data_recv_sampler
    import data_recv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    input  logic i_realign,
    output logic o_rs,
    output logic o_rise,
    output logic o_edge,
    output logic o_strobe
);

    logic            r_meta;
    logic            r_rs;
    logic            r_rs_d;
    logic [PH_W-1:0] r_ph;
    logic            w_strobe;

    assign w_strobe = (r_ph == PH_LAST);

    // two-stage synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_rs   <= 1'b0;
            r_rs_d <= 1'b0;
        end else begin
            r_meta <= i_rxd;
            r_rs   <= r_meta;
            r_rs_d <= r_rs;
        end
    end

    // bit-phase counter: wraps every BIT_CLKS, recentred on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ph <= '0;
        end else if (i_realign) begin
            r_ph <= PH_HALF;
        end else if (w_strobe) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    assign o_rs     = r_rs;
    assign o_rise   = r_rs & ~r_rs_d;
    assign o_edge   = r_rs ^ r_rs_d;
    assign o_strobe = w_strobe;

endmodule

// File: rtl/data_recv.sv
// Serial frame receiver: locks to the leading rising edge of a frame, checks
// the fixed header bit by bit and shifts in the MSB-first payload byte.
//
//  state | meaning
//  GAP   | waiting for IDLE_BITS consecutive zero samples to arm
//  IDLE  | armed, waiting for the frame's first rising edge
//  HDR   | comparing samples against the header pattern
//  DATA  | shifting in the payload byte
module data_recv
    import data_recv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    data_recv_if.slave  bus
);

    state_t                 r_state;
    logic [BIDX_W-1:0]      r_bidx;
    logic [DIDX_W-1:0]      r_didx;
    logic [ZC_W-1:0]        r_zcnt;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_hdr_err;
    logic                   r_busy;

    logic                   w_rs;
    logic                   w_rise;
    logic                   w_edge;
    logic                   w_strobe;
    logic                   w_realign;

    // recentre the sampling phase on the start edge and on every in-frame edge
    assign w_realign = ((r_state == IDLE) && w_rise) ||
                       (((r_state == HDR) || (r_state == DATA)) && w_edge);

    data_recv_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .i_rxd     (bus.rxd),
        .i_realign (w_realign),
        .o_rs      (w_rs),
        .o_rise    (w_rise),
        .o_edge    (w_edge),
        .o_strobe  (w_strobe)
    );

    // frame FSM with its counters, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= GAP;
            r_bidx       <= '0;
            r_didx       <= '0;
            r_zcnt       <= '0;
            r_shreg      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_hdr_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_hdr_err    <= 1'b0;
            case (r_state)
                GAP: begin
                    if (w_strobe) begin
                        if (w_rs) begin
                            r_zcnt <= '0;
                        end else begin
                            if (r_zcnt != ZC_MAX) r_zcnt <= r_zcnt + 1'b1;
                            // arm on the sample that completes the zero run, so a
                            // start edge arriving right behind it is not missed
                            if (r_zcnt >= ZC_ARM) r_state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HDR;
                        r_bidx  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_strobe) begin
                        if (w_rs != HDR_PAT[HDR_LAST - r_bidx]) begin
                            r_hdr_err <= 1'b1;
                            r_busy    <= 1'b0;
                            r_zcnt    <= '0;
                            r_state   <= GAP;
                        end else if (r_bidx == HDR_LAST) begin
                            r_didx  <= '0;
                            r_state <= DATA;
                        end else begin
                            r_bidx <= r_bidx + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_strobe) begin
                        r_shreg <= {r_shreg[DATA_BITS-2:0], w_rs};
                        if (r_didx == DIDX_LAST) begin
                            r_data_out   <= {r_shreg[DATA_BITS-2:0], w_rs};
                            r_data_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_zcnt       <= '0;
                            r_state      <= GAP;
                        end else begin
                            r_didx <= r_didx + 1'b1;
                        end
                    end
                end
                default: r_state <= GAP;
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.hdr_err    = r_hdr_err;
    assign bus.busy       = r_busy;

endmodule
